// File: rtl/fpu_pkg.sv
// Shared types and helpers for the sequential floating-point add/subtract unit.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  localparam int unsigned ST_EXACT     = 0;
  localparam int unsigned ST_OVERFLOW  = 1;
  localparam int unsigned ST_UNDERFLOW = 2;
  localparam int unsigned ST_INEXACT   = 3;

  function automatic int unsigned fpu_width(input int unsigned exp_w, input int unsigned mant_w);
    return 1 + exp_w + mant_w;
  endfunction

  function automatic int unsigned fpu_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [3:0] mk_status(input logic exact, input logic ovf,
                                           input logic unf, input logic inexact);
    logic [3:0] s;
    s               = '0;
    s[ST_EXACT]     = exact;
    s[ST_OVERFLOW]  = ovf;
    s[ST_UNDERFLOW] = unf;
    s[ST_INEXACT]   = inexact;
    return s;
  endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even on a normalised {hidden,frac,G,R,S} mantissa.
module fpu_round_rne
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic [MANT_W+3:0] mant_i,
  input  logic [EXP_W:0]    exp_i,
  output logic [MANT_W-1:0] frac_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              inexact_o,
  output logic              ovf_o
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic             g, r, s, lsb, up;
  logic [MANT_W+1:0] sum;
  logic [EXP_W:0]   exp_full;

  always_comb begin
    g         = mant_i[2];
    r         = mant_i[1];
    s         = mant_i[0];
    lsb       = mant_i[3];
    up        = g & (r | s | lsb);
    sum       = {1'b0, mant_i[MANT_W+3:3]} + {{(MANT_W+1){1'b0}}, up};
    exp_full  = exp_i;
    frac_o    = sum[MANT_W-1:0];
    // Rounding carried out of the hidden bit: mantissa becomes 1.0, bump exponent.
    if (sum[MANT_W+1]) begin
      frac_o   = sum[MANT_W:1];
      exp_full = exp_i + EXP_ONE;
    end
    exp_o     = exp_full[EXP_W-1:0];
    inexact_o = g | r | s;
    ovf_o     = (exp_full >= EXP_MAX);
  end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle FP adder/subtractor: bit-serial alignment and normalisation, RNE rounding.
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic                    clock_100Khz,
  input  logic                    reset,
  input  logic                    start_in,
  input  logic                    op_sub_in,
  input  logic [EXP_W+MANT_W:0]   Op_A_in,
  input  logic [EXP_W+MANT_W:0]   Op_B_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [EXP_W+MANT_W:0]   data_out,
  output logic [3:0]              status_out
);

  localparam int unsigned      W        = fpu_width(EXP_W, MANT_W);
  localparam int unsigned      MW       = MANT_W + 5;
  localparam logic [EXP_W-1:0] DIFF_MAX = EXP_W'(MANT_W + 3);
  localparam logic [EXP_W-1:0] DIFF_ONE = EXP_W'(1);
  localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W+1)'(1);

  state_e            state_q, state_d;
  logic [W-1:0]      opa_q, opa_d, opb_q, opb_d, data_q, data_d;
  logic              sub_q, sub_d, sign_q, sign_d, eff_add_q, eff_add_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [EXP_W-1:0]  diff_q, diff_d;
  logic [MW-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic [3:0]        status_q, status_d;

  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic              sa, sb, a_zero, b_zero;
  logic [MW-1:0]     xa, xb, sum;

  logic [MANT_W-1:0] r_frac;
  logic [EXP_W-1:0]  r_exp;
  logic              r_inexact, r_ovf;

  fpu_round_rne #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_round (
    .mant_i    (ma_q[MW-2:0]),
    .exp_i     (exp_q),
    .frac_o    (r_frac),
    .exp_o     (r_exp),
    .inexact_o (r_inexact),
    .ovf_o     (r_ovf)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sub_d     = sub_q;
    sign_d    = sign_q;
    eff_add_d = eff_add_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    data_d    = data_q;
    status_d  = status_q;

    ea     = opa_q[W-2:MANT_W];
    eb     = opb_q[W-2:MANT_W];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    fa     = a_zero ? '0 : opa_q[MANT_W-1:0];
    fb     = b_zero ? '0 : opb_q[MANT_W-1:0];
    sa     = opa_q[W-1];
    sb     = opb_q[W-1] ^ sub_q;
    xa     = {1'b0, ~a_zero, fa, 3'b000};
    xb     = {1'b0, ~b_zero, fb, 3'b000};
    sum    = eff_add_q ? (ma_q + mb_q) : (ma_q - mb_q);

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          opa_d   = Op_A_in;
          opb_d   = Op_B_in;
          sub_d   = op_sub_in;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        eff_add_d = (sa == sb);
        if (ea == '1) begin
          data_d   = {sa, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          status_d = mk_status(1'b0, 1'b1, 1'b0, 1'b0);
          state_d  = S_DONE;
        end else if (eb == '1) begin
          data_d   = {sb, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          status_d = mk_status(1'b0, 1'b1, 1'b0, 1'b0);
          state_d  = S_DONE;
        end else begin
          if ({ea, fa} >= {eb, fb}) begin
            sign_d = sa;
            exp_d  = {1'b0, ea};
            diff_d = ea - eb;
            ma_d   = xa;
            mb_d   = xb;
          end else begin
            sign_d = sb;
            exp_d  = {1'b0, eb};
            diff_d = eb - ea;
            ma_d   = xb;
            mb_d   = xa;
          end
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // Bit 0 is sticky: everything shifted past it is ORed in, never dropped.
        if (diff_q == '0) begin
          state_d = S_ADD;
        end else if (diff_q > DIFF_MAX) begin
          mb_d    = {{(MW-1){1'b0}}, |mb_q};
          state_d = S_ADD;
        end else begin
          mb_d   = {1'b0, mb_q[MW-1:2], |mb_q[1:0]};
          diff_d = diff_q - DIFF_ONE;
          if (diff_q == DIFF_ONE) state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (sum == '0) begin
          data_d   = '0;
          status_d = mk_status(1'b1, 1'b0, 1'b0, 1'b0);
          state_d  = S_DONE;
        end else begin
          ma_d    = sum;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (ma_q[MW-1]) begin
          ma_d    = {1'b0, ma_q[MW-1:2], |ma_q[1:0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = S_ROUND;
        end else if (ma_q[MW-2]) begin
          state_d = S_ROUND;
        end else if (exp_q <= EXP_ONE) begin
          data_d   = {sign_q, {(W-1){1'b0}}};
          status_d = mk_status(1'b0, 1'b0, 1'b1, 1'b1);
          state_d  = S_DONE;
        end else begin
          ma_d  = ma_q << 1;
          exp_d = exp_q - EXP_ONE;
        end
      end
      S_ROUND: begin
        if (r_ovf) begin
          data_d   = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          status_d = mk_status(1'b0, 1'b1, 1'b0, 1'b1);
        end else begin
          data_d   = {sign_q, r_exp, r_frac};
          status_d = mk_status(~r_inexact, 1'b0, 1'b0, r_inexact);
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      sub_q     <= 1'b0;
      sign_q    <= 1'b0;
      eff_add_q <= 1'b0;
      exp_q     <= '0;
      diff_q    <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      data_q    <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sub_q     <= sub_d;
      sign_q    <= sign_d;
      eff_add_q <= eff_add_d;
      exp_q     <= exp_d;
      diff_q    <= diff_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      data_q    <= data_d;
      status_q  <= status_d;
    end
  end

  assign busy_out   = (state_q != S_IDLE);
  assign done_out   = (state_q == S_DONE);
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Bench for fpu_addsub_seq (single precision): directed cases plus random ops against an exact-arithmetic model.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in, op_sub_in;
  logic [31:0] Op_A_in, Op_B_in;
  logic        busy_out, done_out;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  fpu_addsub_seq #(.EXP_W(8), .MANT_W(23)) dut (
    .clock_100Khz (clk),
    .reset        (reset),
    .start_in     (start_in),
    .op_sub_in    (op_sub_in),
    .Op_A_in      (Op_A_in),
    .Op_B_in      (Op_B_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .data_out     (data_out),
    .status_out   (status_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact sum on wide integers, then a single round-to-nearest-even: {status, result}.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic         sa, sb, s, inx;
    int           ea, eb, emin, p, k, e;
    logic [127:0] va, vb, mag, q, rem, half;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255) return {4'b0010, sa, 8'hFF, 23'd0};
    if (eb == 255) return {4'b0010, sb, 8'hFF, 23'd0};
    emin = (ea < eb) ? ea : eb;
    va = {104'd0, 1'b1, a[22:0]} << (ea - emin);
    vb = {104'd0, 1'b1, b[22:0]} << (eb - emin);
    if (sa == sb) begin
      mag = va + vb; s = sa;
    end else if (va >= vb) begin
      mag = va - vb; s = sa;
    end else begin
      mag = vb - va; s = sb;
    end
    if (mag == 128'd0) return {4'b0001, 32'h0};
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e   = emin + p - 23;
    inx = 1'b0;
    if (p > 23) begin
      k    = p - 23;
      q    = mag >> k;
      rem  = mag & ((128'd1 << k) - 128'd1);
      half = 128'd1 << (k - 1);
      inx  = (rem != 128'd0);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
    end else begin
      q = mag << (23 - p);
    end
    if (q[24]) begin
      q = q >> 1; e = e + 1;
    end
    if (e >= 255) return {4'b1010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b1100, s, 31'd0};
    return {(inx ? 4'b1000 : 4'b0001), s, e[7:0], q[22:0]};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic hold);
    @(negedge clk);
    Op_A_in   = a;
    Op_B_in   = b;
    op_sub_in = sub;
    start_in  = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_in = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] d, output logic [3:0] st);
    logic        busy_ok, held_ok;
    logic [31:0] prev;
    int          lat;
    prev    = data_out;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    lat     = 1;
    while (done_out !== 1'b1 && lat < 100) begin
      busy_ok &= (busy_out === 1'b1);
      held_ok &= (data_out === prev);
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", 64'(done_out), 64'(1));
    chk("busy_during_op", 64'(busy_ok & busy_out), 64'(1));
    chk("data_held_until_done", 64'(held_ok), 64'(1));
    chk("latency_bound", 64'(lat <= 2*23+12), 64'(1));
    d  = data_out;
    st = status_out;
    @(posedge clk); #1;
    chk("done_single_pulse", 64'(done_out), 64'(0));
    chk("busy_low_after_done", 64'(busy_out), 64'(0));
    chk("result_held", 64'(data_out), 64'(d));
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  vec_t        dir [$];
  logic [31:0] d, a, b;
  logic [3:0]  st;
  logic [35:0] ex;
  int          ea, eb;
  logic        sub;

  initial begin
    reset     = 1'b0;
    start_in  = 1'b0;
    op_sub_in = 1'b0;
    Op_A_in   = '0;
    Op_B_in   = '0;
    #12;
    chk("reset_busy",   64'(busy_out),   64'(0));
    chk("reset_done",   64'(done_out),   64'(0));
    chk("reset_data",   64'(data_out),   64'(0));
    chk("reset_status", 64'(status_out), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    dir.push_back('{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'b0001});
    dir.push_back('{32'h40B80000, 32'h3FA00000, 1'b1, 32'h40900000, 4'b0001});
    dir.push_back('{32'h41000000, 32'hC1000000, 1'b0, 32'h00000000, 4'b0001});
    dir.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010});
    dir.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b1000});
    dir.push_back('{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b1000});
    dir.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0010});
    dir.push_back('{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0010});
    dir.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b1100});
    dir.push_back('{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0001});

    foreach (dir[i]) begin
      issue(dir[i].a, dir[i].b, dir[i].sub, 1'b0);
      wait_done(d, st);
      chk($sformatf("dir%0d_data", i), 64'(d), 64'(dir[i].res));
      chk($sformatf("dir%0d_status", i), 64'(st), 64'(dir[i].st));
    end

    // start_in held high across a whole operation
    issue(32'h3FC00000, 32'h40100000, 1'b0, 1'b1);
    wait_done(d, st);
    chk("held_first_data", 64'(d), 64'(32'h40700000));
    @(posedge clk); #1;
    chk("held_reaccept_after_idle", 64'(busy_out), 64'(1));
    start_in = 1'b0;
    wait_done(d, st);
    chk("held_second_data", 64'(d), 64'(32'h40700000));
    chk("held_second_status", 64'(st), 64'(4'b0001));

    // reset asserted during alignment of 1024.0 + 1.0
    issue(32'h44800000, 32'h3F800000, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midop_reset_busy",   64'(busy_out),   64'(0));
    chk("midop_reset_done",   64'(done_out),   64'(0));
    chk("midop_reset_data",   64'(data_out),   64'(0));
    chk("midop_reset_status", 64'(status_out), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    issue(32'h44800000, 32'h3F800000, 1'b0, 1'b0);
    wait_done(d, st);
    chk("after_reset_data",   64'(d),  64'(32'h44802000));
    chk("after_reset_status", 64'(st), 64'(4'b0001));

    for (int i = 0; i < 40; i++) begin
      ea = int'($urandom_range(160, 90));
      if (i % 2 == 1) eb = ea + int'($urandom_range(2, 0)) - 1;
      else            eb = int'($urandom_range(160, 90));
      a   = {1'($urandom), 8'(ea), 23'($urandom)};
      b   = {1'($urandom), 8'(eb), 23'($urandom)};
      if (i % 4 == 1) b[30:0] = a[30:0];
      sub = 1'($urandom);
      ex  = ref_add(a, b, sub);
      issue(a, b, sub, 1'b0);
      wait_done(d, st);
      chk($sformatf("rand%0d_data %h %s %h", i, a, sub ? "-" : "+", b), 64'(d), 64'(ex[31:0]));
      chk($sformatf("rand%0d_status", i), 64'(st), 64'(ex[35:32]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
